// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// flags, overflow/underflow pulses and an empty-state read/write bypass.
module fifo_param #(
  parameter int MEM_DEPTH = 32,
  parameter int MEM_WIDTH = 8,
  parameter int AF_LEVEL  = MEM_DEPTH - 2,
  parameter int AE_LEVEL  = 2,
  parameter int CW        = $clog2(MEM_DEPTH + 1)
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 CLEAR_N,
  input  logic                 READ,
  input  logic                 WRITE,
  input  logic [MEM_WIDTH-1:0] DATA_IN,
  output logic [MEM_WIDTH-1:0] DATA_OUT,
  output logic                 F_FULL_N,
  output logic                 F_EMPTY_N,
  output logic                 F_AFULL_N,
  output logic                 F_AEMPTY_N,
  output logic [CW-1:0]        USE_DW,
  output logic                 OVF,
  output logic                 UDF
);

  localparam int            AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(MEM_DEPTH);
  localparam logic [CW-1:0] AF_C      = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C      = CW'(AE_LEVEL);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic [AW-1:0]        waddr;
  logic [AW-1:0]        raddr;
  logic                 empty;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;
  logic                 do_bypass;
  logic                 ovf_nxt;
  logic                 udf_nxt;
  logic [CW-1:0]        use_nxt;

  assign empty = (USE_DW == '0);
  assign full  = (USE_DW == DEPTH_C);

  // Decision is taken on registered count only; clear overrides every request.
  always_comb begin
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_bypass = 1'b0;
    ovf_nxt   = 1'b0;
    udf_nxt   = 1'b0;
    use_nxt   = USE_DW;
    if (!CLEAR_N) begin
      use_nxt = '0;
    end else if (READ && WRITE) begin
      if (empty) begin
        do_bypass = 1'b1;
      end else begin
        do_push = 1'b1;
        do_pop  = 1'b1;
      end
    end else if (READ) begin
      if (empty) begin
        udf_nxt = 1'b1;
      end else begin
        do_pop  = 1'b1;
        use_nxt = USE_DW - CW'(1);
      end
    end else if (WRITE) begin
      if (full) begin
        ovf_nxt = 1'b1;
      end else begin
        do_push = 1'b1;
        use_nxt = USE_DW + CW'(1);
      end
    end
  end

  // Storage is deliberately left unreset; the count alone defines valid words.
  always_ff @(posedge CLOCK) begin
    if (do_push) begin
      mem[waddr] <= DATA_IN;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      waddr      <= '0;
      raddr      <= '0;
      DATA_OUT   <= '0;
      USE_DW     <= '0;
      F_FULL_N   <= 1'b1;
      F_EMPTY_N  <= 1'b0;
      F_AFULL_N  <= 1'b1;
      F_AEMPTY_N <= 1'b0;
      OVF        <= 1'b0;
      UDF        <= 1'b0;
    end else begin
      if (!CLEAR_N) begin
        waddr <= '0;
        raddr <= '0;
      end else begin
        if (do_push) begin
          waddr <= (waddr == LAST_ADDR) ? '0 : waddr + AW'(1);
        end
        if (do_pop) begin
          raddr    <= (raddr == LAST_ADDR) ? '0 : raddr + AW'(1);
          DATA_OUT <= mem[raddr];
        end
        if (do_bypass) begin
          DATA_OUT <= DATA_IN;
        end
      end
      // Flags follow the next count so they always match USE_DW.
      USE_DW     <= use_nxt;
      F_FULL_N   <= (use_nxt != DEPTH_C);
      F_EMPTY_N  <= (use_nxt != '0);
      F_AFULL_N  <= (use_nxt < AF_C);
      F_AEMPTY_N <= (use_nxt > AE_C);
      OVF        <= ovf_nxt;
      UDF        <= udf_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param at depth 5, AF=4, AE=1.
module tb_fifo_param;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic       CLEAR_N;
  logic       READ;
  logic       WRITE;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       F_FULL_N;
  logic       F_EMPTY_N;
  logic       F_AFULL_N;
  logic       F_AEMPTY_N;
  logic [2:0] USE_DW;
  logic       OVF;
  logic       UDF;

  int total = 0;
  int bad   = 0;

  fifo_param #(.MEM_DEPTH(5), .MEM_WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .CLEAR_N(CLEAR_N), .READ(READ), .WRITE(WRITE),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .F_FULL_N(F_FULL_N), .F_EMPTY_N(F_EMPTY_N),
    .F_AFULL_N(F_AFULL_N), .F_AEMPTY_N(F_AEMPTY_N), .USE_DW(USE_DW), .OVF(OVF), .UDF(UDF)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic drive(input logic rd, input logic wr, input logic [7:0] d);
    READ = rd; WRITE = wr; DATA_IN = d;
    @(posedge CLOCK); #1;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; CLEAR_N = 1'b1; READ = 1'b0; WRITE = 1'b0; DATA_IN = 8'h00;
    repeat (2) @(posedge CLOCK);
    #1;
    total++;
    if ({DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N, OVF, UDF} !== {8'h00, 3'd0, 6'b101000}) begin
      bad++;
      $display("FAIL reset_values: got dout=%0h use=%0d ff=%b fe=%b af=%b ae=%b ovf=%b udf=%b want 0 0 1 0 1 0 0 0",
               DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N, OVF, UDF);
    end
    RESET_N = 1'b1;
  endtask

  task automatic test_fill;
    logic [7:0] pat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [4:0] ae_tab = 5'b11110;
    logic [4:0] af_tab = 5'b00111;
    logic [4:0] ff_tab = 5'b01111;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, pat[i]);
      total++;
      if ({USE_DW, F_AEMPTY_N, F_AFULL_N, F_FULL_N, F_EMPTY_N} !== {3'(i + 1), ae_tab[i], af_tab[i], ff_tab[i], 1'b1}) begin
        bad++;
        $display("FAIL fill_%0d: got use=%0d ae=%b af=%b ff=%b fe=%b want use=%0d ae=%b af=%b ff=%b fe=1",
                 i, USE_DW, F_AEMPTY_N, F_AFULL_N, F_FULL_N, F_EMPTY_N, i + 1, ae_tab[i], af_tab[i], ff_tab[i]);
      end
    end
    drive(1'b0, 1'b1, 8'h66);
    total++;
    if (OVF !== 1'b1 || USE_DW !== 3'd5) begin
      bad++;
      $display("FAIL overflow: got ovf=%b use=%0d want ovf=1 use=5", OVF, USE_DW);
    end
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (OVF !== 1'b0) begin
      bad++;
      $display("FAIL overflow_pulse_width: got ovf=%b want 0", OVF);
    end
  endtask

  task automatic test_drain;
    logic [7:0] pat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [4:0] ae_tab = 5'b00111;
    logic [4:0] fe_tab = 5'b01111;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'h00);
      total++;
      if ({DATA_OUT, USE_DW, F_EMPTY_N, F_AEMPTY_N} !== {pat[i], 3'(4 - i), fe_tab[i], ae_tab[i]}) begin
        bad++;
        $display("FAIL drain_%0d: got dout=%0h use=%0d fe=%b ae=%b want dout=%0h use=%0d fe=%b ae=%b",
                 i, DATA_OUT, USE_DW, F_EMPTY_N, F_AEMPTY_N, pat[i], 4 - i, fe_tab[i], ae_tab[i]);
      end
    end
    drive(1'b1, 1'b0, 8'h00);
    total++;
    if (UDF !== 1'b1 || DATA_OUT !== 8'h55 || USE_DW !== 3'd0) begin
      bad++;
      $display("FAIL underflow: got udf=%b dout=%0h use=%0d want udf=1 dout=55 use=0", UDF, DATA_OUT, USE_DW);
    end
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (UDF !== 1'b0) begin
      bad++;
      $display("FAIL underflow_pulse_width: got udf=%b want 0", UDF);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    // Offset both pointers by one so every round crosses the 4->0 wrap mid-burst.
    drive(1'b0, 1'b1, 8'hEE);
    drive(1'b1, 1'b0, 8'h00);
    total++;
    if (DATA_OUT !== 8'hEE) begin
      bad++;
      $display("FAIL wrap_offset: got dout=%0h want ee", DATA_OUT);
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        d = 8'((r + 1) * 16 + i + 1);
        drive(1'b0, 1'b1, d);
      end
      total++;
      if (USE_DW !== 3'd5 || F_FULL_N !== 1'b0) begin
        bad++;
        $display("FAIL wrap_full_%0d: got use=%0d ff=%b want use=5 ff=0", r, USE_DW, F_FULL_N);
      end
      for (int i = 0; i < 5; i++) begin
        d = 8'((r + 1) * 16 + i + 1);
        drive(1'b1, 1'b0, 8'h00);
        total++;
        if (DATA_OUT !== d) begin
          bad++;
          $display("FAIL wrap_order_%0d_%0d: got dout=%0h want %0h", r, i, DATA_OUT, d);
        end
      end
    end
  endtask

  task automatic test_bypass;
    drive(1'b1, 1'b1, 8'hA5);
    total++;
    if ({DATA_OUT, USE_DW, UDF, F_EMPTY_N} !== {8'hA5, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL bypass: got dout=%0h use=%0d udf=%b fe=%b want a5 0 0 0", DATA_OUT, USE_DW, UDF, F_EMPTY_N);
    end
  endtask

  task automatic test_full_simul;
    logic [7:0] pat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] exp [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h99};
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, pat[i]);
    drive(1'b1, 1'b1, 8'h99);
    total++;
    if ({DATA_OUT, USE_DW, OVF, F_FULL_N} !== {8'h11, 3'd5, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL full_simul: got dout=%0h use=%0d ovf=%b ff=%b want 11 5 0 0", DATA_OUT, USE_DW, OVF, F_FULL_N);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'h00);
      total++;
      if (DATA_OUT !== exp[i]) begin
        bad++;
        $display("FAIL full_simul_drain_%0d: got dout=%0h want %0h", i, DATA_OUT, exp[i]);
      end
    end
  endtask

  task automatic test_clear;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(8'hC0 + i));
    total++;
    if (USE_DW !== 3'd3) begin
      bad++;
      $display("FAIL clear_setup: got use=%0d want 3", USE_DW);
    end
    CLEAR_N = 1'b0;
    drive(1'b0, 1'b1, 8'hDD);
    CLEAR_N = 1'b1;
    total++;
    if ({USE_DW, F_EMPTY_N, F_AEMPTY_N, F_FULL_N, DATA_OUT, OVF} !== {3'd0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0}) begin
      bad++;
      $display("FAIL clear_priority: got use=%0d fe=%b ae=%b ff=%b dout=%0h ovf=%b want 0 0 0 1 99 0",
               USE_DW, F_EMPTY_N, F_AEMPTY_N, F_FULL_N, DATA_OUT, OVF);
    end
    drive(1'b0, 1'b1, 8'h77);
    drive(1'b1, 1'b0, 8'h00);
    total++;
    if (DATA_OUT !== 8'h77 || USE_DW !== 3'd0) begin
      bad++;
      $display("FAIL clear_then_rw: got dout=%0h use=%0d want 77 0", DATA_OUT, USE_DW);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b0, 1'b1, 8'hC1);
    drive(1'b0, 1'b1, 8'hC2);
    DATA_IN = 8'hC3;
    #2;
    RESET_N = 1'b0;
    #1;
    total++;
    if ({DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N, OVF, UDF} !== {8'h00, 3'd0, 6'b101000}) begin
      bad++;
      $display("FAIL async_reset_now: got dout=%0h use=%0d ff=%b fe=%b af=%b ae=%b ovf=%b udf=%b want 0 0 1 0 1 0 0 0",
               DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N, OVF, UDF);
    end
    drive(1'b0, 1'b1, 8'hC4);
    total++;
    if (USE_DW !== 3'd0 || F_EMPTY_N !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_hold: got use=%0d fe=%b want 0 0", USE_DW, F_EMPTY_N);
    end
    RESET_N = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (USE_DW !== 3'd0 || F_EMPTY_N !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_release: got use=%0d fe=%b want 0 0", USE_DW, F_EMPTY_N);
    end
    drive(1'b0, 1'b1, 8'h3C);
    drive(1'b1, 1'b0, 8'h00);
    total++;
    if (DATA_OUT !== 8'h3C || USE_DW !== 3'd0) begin
      bad++;
      $display("FAIL async_reset_resume: got dout=%0h use=%0d want 3c 0", DATA_OUT, USE_DW);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_bypass();
    test_full_simul();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
